// File: rtl/vc_input_port.sv
// vc_input_port: mesh-router input port with per-VC flit FIFOs, XY routing and VA/SA request generation.
// Build option INPUT_PORT_CREDIT_EN adds credit_o, a per-VC pulse one cycle after each pop.
package vc_input_port_pkg;
    localparam int MESH_SIZE_X = 4;
    localparam int MESH_SIZE_Y = 4;
    localparam int VC_ID_W     = 2;
    localparam int DEST_W      = 2;
    localparam int PAYLOAD_W   = 8;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
    typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        logic [DEST_W-1:0]    x_dest;
        logic [DEST_W-1:0]    y_dest;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);
endpackage

module vc_input_port
    import vc_input_port_pkg::*;
#(
    parameter int VC_NUM        = 2,
    parameter int BUFFER_SIZE   = 8,
    parameter int X_CURRENT     = MESH_SIZE_X / 2,
    parameter int Y_CURRENT     = MESH_SIZE_Y / 2,
    parameter int OFF_THRESHOLD = BUFFER_SIZE - 2,
    parameter int ON_THRESHOLD  = BUFFER_SIZE / 2,
    localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  flit_t                           data_i,
    input  logic                            valid_flit_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]  va_new_vc_i,
    input  logic [VC_NUM-1:0]               va_valid_i,
    input  logic [VC_SIZE-1:0]              sa_sel_vc_i,
    input  logic                            sa_valid_i,
    output flit_t                           xb_flit_o,
    output logic                            xb_valid_o,
    output logic [VC_NUM-1:0]               is_on_off_o,
    output logic [VC_NUM-1:0]               is_allocatable_vc_o,
    output logic [VC_NUM-1:0]               va_request_o,
    output logic [VC_NUM-1:0]               sa_request_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]  sa_downstream_vc_o,
    output port_t [VC_NUM-1:0]              out_port_o,
    output logic [VC_NUM-1:0]               is_full_o,
    output logic [VC_NUM-1:0]               is_empty_o,
    output logic [VC_NUM-1:0]               err_o
`ifdef INPUT_PORT_CREDIT_EN
    ,
    output logic [VC_NUM-1:0]               credit_o
`endif
);
    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0]  OFF_CNT  = CNT_W'(OFF_THRESHOLD);
    localparam logic [CNT_W-1:0]  ON_CNT   = CNT_W'(ON_THRESHOLD);
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [DEST_W-1:0] X_CUR    = DEST_W'(X_CURRENT);
    localparam logic [DEST_W-1:0] Y_CUR    = DEST_W'(Y_CURRENT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_VA = 2'd1, ST_ACTIVE = 2'd2} vc_state_t;

    flit_t                          mem_r [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]               wr_ptr_r [VC_NUM];
    logic [PTR_W-1:0]               rd_ptr_r [VC_NUM];
    logic [CNT_W-1:0]               count_r [VC_NUM];
    logic [CNT_W-1:0]               count_next_s [VC_NUM];
    vc_state_t                      state_r [VC_NUM];
    vc_state_t                      state_next_s [VC_NUM];
    flit_t                          front_s [VC_NUM];
    flit_t                          rew_s [VC_NUM];
    flit_t                          pop_flit_s;
    flit_t                          xb_flit_r;
    logic                           xb_valid_r;
    logic                           wr_head_s;
    logic [VC_NUM-1:0]              in_packet_r, err_r, on_off_r, alloc_r, va_req_r, sa_req_r;
    logic [VC_NUM-1:0]              full_r, empty_r, on_off_next_s;
    logic [VC_NUM-1:0]              wr_sel_s, proto_ok_s, room_s, push_s, pop_s, drop_s;
    logic [VC_NUM-1:0]              front_head_s, front_last_s;
    logic [VC_NUM-1:0][VC_SIZE-1:0] ds_vc_r;
    port_t [VC_NUM-1:0]             route_r;

    function automatic port_t route_xy(input logic [DEST_W-1:0] xd, input logic [DEST_W-1:0] yd);
        port_t p;
        if (xd > X_CUR)      p = EAST;
        else if (xd < X_CUR) p = WEST;
        else if (yd > Y_CUR) p = SOUTH;
        else if (yd < Y_CUR) p = NORTH;
        else                 p = LOCAL;
        return p;
    endfunction

    // Per-VC write acceptance, pop decode, occupancy/state next values and the rewritten output flit.
    always_comb begin
        wr_head_s  = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
        pop_flit_s = flit_t'({FLIT_W{1'b0}});
        for (int v = 0; v < VC_NUM; v++) begin
            front_s[v]         = mem_r[v][rd_ptr_r[v]];
            front_head_s[v]    = (front_s[v].flit_label == HEAD) || (front_s[v].flit_label == HEADTAIL);
            front_last_s[v]    = (front_s[v].flit_label == TAIL) || (front_s[v].flit_label == HEADTAIL);
            rew_s[v]           = front_s[v];
            rew_s[v].vc_id     = VC_ID_W'(ds_vc_r[v]);
            wr_sel_s[v]        = valid_flit_i && (data_i.vc_id == VC_ID_W'(v));
            pop_s[v]           = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v)) &&
                                 (state_r[v] == ST_ACTIVE) && (count_r[v] != CNT_ZERO);
            proto_ok_s[v]      = wr_head_s ? !in_packet_r[v] : in_packet_r[v];
            // A full FIFO still takes a write when the same cycle pops it.
            room_s[v]          = (count_r[v] != FULL_CNT) || pop_s[v];
            push_s[v]          = wr_sel_s[v] && proto_ok_s[v] && room_s[v];
            drop_s[v]          = wr_sel_s[v] && !(proto_ok_s[v] && room_s[v]);
            pop_flit_s         = pop_flit_s | (flit_t'({FLIT_W{pop_s[v]}}) & rew_s[v]);

            case ({push_s[v], pop_s[v]})
                2'b10:   count_next_s[v] = count_r[v] + CNT_ONE;
                2'b01:   count_next_s[v] = count_r[v] - CNT_ONE;
                default: count_next_s[v] = count_r[v];
            endcase

            if (count_next_s[v] >= OFF_CNT)     on_off_next_s[v] = 1'b0;
            else if (count_next_s[v] <= ON_CNT) on_off_next_s[v] = 1'b1;
            else                                on_off_next_s[v] = on_off_r[v];

            case (state_r[v])
                ST_IDLE: begin
                    if ((count_r[v] != CNT_ZERO) && front_head_s[v]) state_next_s[v] = ST_VA;
                    else                                             state_next_s[v] = ST_IDLE;
                end
                ST_VA: begin
                    if (va_valid_i[v]) state_next_s[v] = ST_ACTIVE;
                    else               state_next_s[v] = ST_VA;
                end
                ST_ACTIVE: begin
                    if (pop_s[v] && front_last_s[v]) state_next_s[v] = ST_IDLE;
                    else                             state_next_s[v] = ST_ACTIVE;
                end
                default: state_next_s[v] = ST_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (push_s[v]) mem_r[v][wr_ptr_r[v]] <= data_i;
        end
    end

    // Pointers, packet trackers, VC state, routes and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                count_r[v]  <= CNT_ZERO;
                wr_ptr_r[v] <= PTR_ZERO;
                rd_ptr_r[v] <= PTR_ZERO;
                state_r[v]  <= ST_IDLE;
                ds_vc_r[v]  <= {VC_SIZE{1'b0}};
                route_r[v]  <= LOCAL;
            end
            in_packet_r <= {VC_NUM{1'b0}};
            err_r       <= {VC_NUM{1'b0}};
            on_off_r    <= {VC_NUM{1'b1}};
            alloc_r     <= {VC_NUM{1'b1}};
            va_req_r    <= {VC_NUM{1'b0}};
            sa_req_r    <= {VC_NUM{1'b0}};
            full_r      <= {VC_NUM{1'b0}};
            empty_r     <= {VC_NUM{1'b1}};
            xb_valid_r  <= 1'b0;
            xb_flit_r   <= flit_t'({FLIT_W{1'b0}});
        end else begin
            xb_valid_r <= |pop_s;
            if (|pop_s) xb_flit_r <= pop_flit_s;
            for (int v = 0; v < VC_NUM; v++) begin
                count_r[v]  <= count_next_s[v];
                state_r[v]  <= state_next_s[v];
                on_off_r[v] <= on_off_next_s[v];
                full_r[v]   <= (count_next_s[v] == FULL_CNT);
                empty_r[v]  <= (count_next_s[v] == CNT_ZERO);
                alloc_r[v]  <= (state_next_s[v] == ST_IDLE) && (count_next_s[v] == CNT_ZERO);
                va_req_r[v] <= (state_next_s[v] == ST_VA);
                sa_req_r[v] <= (state_next_s[v] == ST_ACTIVE) && (count_next_s[v] != CNT_ZERO);
                if (drop_s[v]) err_r[v] <= 1'b1;
                if ((state_r[v] == ST_VA) && va_valid_i[v]) ds_vc_r[v] <= va_new_vc_i[v];
                if (pop_s[v]) rd_ptr_r[v] <= (rd_ptr_r[v] == LAST_PTR) ? PTR_ZERO : rd_ptr_r[v] + PTR_ONE;
                if (push_s[v]) begin
                    wr_ptr_r[v] <= (wr_ptr_r[v] == LAST_PTR) ? PTR_ZERO : wr_ptr_r[v] + PTR_ONE;
                    if (wr_head_s) route_r[v] <= route_xy(data_i.x_dest, data_i.y_dest);
                    if (data_i.flit_label == HEAD) in_packet_r[v] <= 1'b1;
                    else if (data_i.flit_label != BODY) in_packet_r[v] <= 1'b0;
                end
            end
        end
    end

`ifdef INPUT_PORT_CREDIT_EN
    logic [VC_NUM-1:0] credit_r;

    // One credit per popped flit, aligned with the crossbar valid.
    always_ff @(posedge clk) begin
        if (rst) credit_r <= {VC_NUM{1'b0}};
        else     credit_r <= pop_s;
    end

    assign credit_o = credit_r;
`endif

    assign xb_flit_o           = xb_flit_r;
    assign xb_valid_o          = xb_valid_r;
    assign is_on_off_o         = on_off_r;
    assign is_allocatable_vc_o = alloc_r;
    assign va_request_o        = va_req_r;
    assign sa_request_o        = sa_req_r;
    assign sa_downstream_vc_o  = ds_vc_r;
    assign out_port_o          = route_r;
    assign is_full_o           = full_r;
    assign is_empty_o          = empty_r;
    assign err_o               = err_r;
endmodule

// File: tb/tb_vc_input_port.sv
// Directed self-checking bench for vc_input_port (VC_NUM=2, BUFFER_SIZE=8, router at (2,2)).
module tb_vc_input_port;
    import vc_input_port_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    flit_t           data_i;
    logic            valid_flit_i;
    logic [1:0][0:0] va_new_vc_i;
    logic [1:0]      va_valid_i;
    logic [0:0]      sa_sel_vc_i;
    logic            sa_valid_i;
    flit_t           xb_flit_o;
    logic            xb_valid_o;
    logic [1:0]      is_on_off_o, is_allocatable_vc_o, va_request_o, sa_request_o;
    logic [1:0][0:0] sa_downstream_vc_o;
    port_t [1:0]     out_port_o;
    logic [1:0]      is_full_o, is_empty_o, err_o;
`ifdef INPUT_PORT_CREDIT_EN
    logic [1:0]      credit_o;
`endif

    int checks   = 0;
    int failures = 0;

    vc_input_port dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
        .va_new_vc_i(va_new_vc_i), .va_valid_i(va_valid_i),
        .sa_sel_vc_i(sa_sel_vc_i), .sa_valid_i(sa_valid_i),
        .xb_flit_o(xb_flit_o), .xb_valid_o(xb_valid_o),
        .is_on_off_o(is_on_off_o), .is_allocatable_vc_o(is_allocatable_vc_o),
        .va_request_o(va_request_o), .sa_request_o(sa_request_o),
        .sa_downstream_vc_o(sa_downstream_vc_o), .out_port_o(out_port_o),
        .is_full_o(is_full_o), .is_empty_o(is_empty_o), .err_o(err_o)
`ifdef INPUT_PORT_CREDIT_EN
        , .credit_o(credit_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y, input int p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_ID_W'(vc);
        f.x_dest     = DEST_W'(x);
        f.y_dest     = DEST_W'(y);
        f.payload    = PAYLOAD_W'(p);
        return f;
    endfunction

    task automatic put(input flit_t f);
        data_i       = f;
        valid_flit_i = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_xbv"}, xb_valid_o, 0);
        check({tag, "_xbf"}, xb_flit_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_onoff"}, is_on_off_o, 2'b11);
        check({tag, "_alloc"}, is_allocatable_vc_o, 2'b11);
        check({tag, "_req"}, {va_request_o, sa_request_o}, 0);
        check({tag, "_ds"}, sa_downstream_vc_o, 0);
        check({tag, "_port"}, {out_port_o[1], out_port_o[0]}, {LOCAL, LOCAL});
        check({tag, "_full"}, is_full_o, 0);
        check({tag, "_empty"}, is_empty_o, 2'b11);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_i = mk(HEAD, 0, 0, 0, 0); valid_flit_i = 1'b0;
        va_new_vc_i = '{default: 1'b0}; va_valid_i = 2'b00; sa_sel_vc_i = 1'b0; sa_valid_i = 1'b0;
        tick(); tick();
        check_reset("rst0");
        rst = 1'b0;

        // HEADTAIL on VC1 heading east, full VA/SA round trip
        put(mk(HEADTAIL, 1, 3, 0, 8'hA5)); tick(); valid_flit_i = 1'b0;
        check("t1_port", out_port_o[1], EAST);
        check("t1_empty", is_empty_o[1], 0);
        check("t1_vareq0", va_request_o[1], 0);
        tick();
        check("t1_vareq1", va_request_o[1], 1);
        va_valid_i = 2'b10; va_new_vc_i[1] = 1'b0; tick(); va_valid_i = 2'b00;
        check("t1_sareq", sa_request_o[1], 1);
        check("t1_vareq_clr", va_request_o[1], 0);
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1; tick(); sa_valid_i = 1'b0;
        check("t1_xbv", xb_valid_o, 1);
        check("t1_xbf", xb_flit_o, mk(HEADTAIL, 0, 3, 0, 8'hA5));
        check("t1_idle", {is_allocatable_vc_o[1], sa_request_o[1]}, 2'b10);
`ifdef INPUT_PORT_CREDIT_EN
        check("t1_credit", credit_o, 2'b10);
`endif
        tick();
        check("t1_xbv_clr", xb_valid_o, 0);

        // Fill VC0 with a long packet: on/off hysteresis, full, overflow drop
        for (int i = 0; i < 8; i++) begin
            put(mk((i == 0) ? HEAD : BODY, 0, 2, 1, i)); tick();
            check($sformatf("t2_onoff_%0d", i + 1), is_on_off_o[0], (i + 1 >= 6) ? 0 : 1);
            if (i == 3) check("t2_empty4", is_empty_o[0], 0);
        end
        check("t2_port", out_port_o[0], NORTH);
        check("t2_full", is_full_o[0], 1);
        check("t2_noerr", err_o[0], 0);
        put(mk(BODY, 0, 2, 1, 8)); tick(); valid_flit_i = 1'b0;
        check("t2_ovf_err", err_o[0], 1);
        check("t2_ovf_full", is_full_o[0], 1);
        va_valid_i = 2'b01; va_new_vc_i[0] = 1'b1; tick(); va_valid_i = 2'b00;
        check("t2_sareq", sa_request_o[0], 1);
        check("t2_ds", sa_downstream_vc_o[0], 1);
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0;
        put(mk(BODY, 0, 2, 1, 9)); tick(); valid_flit_i = 1'b0;
        check("t2_wp_full", is_full_o[0], 1);
        check("t2_wp_flit", xb_flit_o, mk(HEAD, 1, 2, 1, 0));
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("t2_pop%0d", k), xb_flit_o, mk(BODY, 1, 2, 1, k));
            check($sformatf("t2_onoff_pop%0d", k), is_on_off_o[0], (k == 4) ? 1 : 0);
        end
        sa_valid_i = 1'b0;
        check("t2_notfull", is_full_o[0], 0);

        do_reset();
        check_reset("rst_mid");

        // Orphan BODY/TAIL on VC0
        put(mk(BODY, 0, 2, 2, 1)); tick();
        put(mk(TAIL, 0, 2, 2, 2)); tick(); valid_flit_i = 1'b0;
        check("t3_empty", is_empty_o[0], 1);
        check("t3_err", err_o, 2'b01);
        do_reset();

        // Repeated HEAD on VC1 is dropped
        put(mk(HEAD, 1, 1, 2, 1)); tick();
        put(mk(HEAD, 1, 1, 2, 2)); tick();
        put(mk(BODY, 1, 1, 2, 3)); tick();
        put(mk(TAIL, 1, 1, 2, 4)); tick(); valid_flit_i = 1'b0;
        check("t4_err", err_o, 2'b10);
        check("t4_port", out_port_o[1], WEST);
        va_valid_i = 2'b10; va_new_vc_i[1] = 1'b0; tick(); va_valid_i = 2'b00;
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1;
        tick();
        check("t4_f0", {xb_valid_o, xb_flit_o}, {1'b1, mk(HEAD, 0, 1, 2, 1)});
        tick();
        check("t4_f1", {xb_valid_o, xb_flit_o}, {1'b1, mk(BODY, 0, 1, 2, 3)});
        tick();
        check("t4_f2", {xb_valid_o, xb_flit_o}, {1'b1, mk(TAIL, 0, 1, 2, 4)});
        check("t4_empty", is_empty_o[1], 1);
`ifdef INPUT_PORT_CREDIT_EN
        check("t4_credit", credit_o, 2'b10);
`endif
        tick(); sa_valid_i = 1'b0;
        check("t4_ignored", xb_valid_o, 0);
`ifdef INPUT_PORT_CREDIT_EN
        check("t4_credit_clr", credit_o, 2'b00);
`endif

        // Interleaved packets on VC0/VC1 with alternating grants
        put(mk(HEAD, 0, 2, 3, 8'h10)); tick();
        put(mk(HEAD, 1, 2, 2, 8'h20)); tick();
        check("t5_port0", out_port_o[0], SOUTH);
        put(mk(TAIL, 0, 2, 3, 8'h11)); va_valid_i = 2'b01; va_new_vc_i[0] = 1'b1; tick();
        check("t5_port1", out_port_o[1], LOCAL);
        check("t5_sareq0", sa_request_o, 2'b01);
        put(mk(TAIL, 1, 2, 2, 8'h21)); va_valid_i = 2'b10; va_new_vc_i[1] = 1'b0; tick();
        valid_flit_i = 1'b0; va_valid_i = 2'b00;
        check("t5_sareq", sa_request_o, 2'b11);
        sa_valid_i = 1'b1;
        sa_sel_vc_i = 1'b0; tick();
        check("t5_g0", {xb_valid_o, xb_flit_o}, {1'b1, mk(HEAD, 1, 2, 3, 8'h10)});
        sa_sel_vc_i = 1'b1; tick();
        check("t5_g1", {xb_valid_o, xb_flit_o}, {1'b1, mk(HEAD, 0, 2, 2, 8'h20)});
        sa_sel_vc_i = 1'b0; tick();
        check("t5_g2", {xb_valid_o, xb_flit_o}, {1'b1, mk(TAIL, 1, 2, 3, 8'h11)});
        sa_sel_vc_i = 1'b1; tick();
        check("t5_g3", {xb_valid_o, xb_flit_o}, {1'b1, mk(TAIL, 0, 2, 2, 8'h21)});
        sa_valid_i = 1'b0; tick();
        check("t5_done", {xb_valid_o, is_allocatable_vc_o}, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vc_input_port.md
Name: vc_input_port

Overview:
- Parametrised next-generation router input port: one flit FIFO per virtual channel (VC_NUM VCs), each BUFFER_SIZE deep.
- Per-VC packet state machine, XY route computation on HEAD flits, VA/SA request generation, and crossbar output with VC rewrite.
- New over the previous port:
  - arbitrary VC count and non-power-of-two depth;
  - hysteresis on/off flow control;
  - explicit crossbar valid;
  - sticky per-VC protocol-error detection.
- Sits between the upstream link and the crossbar/allocators of a mesh router.

Parameters:
- VC_NUM, 2, number of virtual channels; VC_SIZE = max(1, $clog2(VC_NUM)).
- BUFFER_SIZE, 8, flits per VC FIFO; any value >= 2.
- X_CURRENT, MESH_SIZE_X/2, router X coordinate.
- Y_CURRENT, MESH_SIZE_Y/2, router Y coordinate.
- OFF_THRESHOLD, BUFFER_SIZE-2, occupancy at or above which the VC signals off.
- ON_THRESHOLD, BUFFER_SIZE/2, occupancy at or below which an off VC returns on; must be < OFF_THRESHOLD.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  flit_t  incoming flit; vc_id selects the VC.
- valid_flit_i  in  1  data_i valid this cycle.
- va_new_vc_i  in  VC_NUM x VC_SIZE  downstream VC granted by VA, per VC.
- va_valid_i  in  VC_NUM  VA grant strobe, per VC.
- sa_sel_vc_i  in  VC_SIZE  VC granted by SA.
- sa_valid_i  in  1  SA grant strobe.
- xb_flit_o  out  flit_t  registered flit to crossbar.
- xb_valid_o  out  1  xb_flit_o valid.
- is_on_off_o  out  VC_NUM  1 = upstream may send on VC.
- is_allocatable_vc_o  out  VC_NUM  VC idle and empty.
- va_request_o  out  VC_NUM  VC awaiting VA.
- sa_request_o  out  VC_NUM  VC allocated and non-empty.
- sa_downstream_vc_o  out  VC_NUM x VC_SIZE  latched downstream VC.
- out_port_o  out  VC_NUM x port_t  computed output port.
- is_full_o  out  VC_NUM  FIFO occupancy == BUFFER_SIZE.
- is_empty_o  out  VC_NUM  occupancy == 0.
- err_o  out  VC_NUM  sticky protocol error.

Behaviour:
Reset:
- All FIFOs empty, all VCs IDLE.
- xb_valid_o=0, xb_flit_o=0, err_o=0, is_on_off_o all 1, is_allocatable_vc_o all 1, requests 0.
- sa_downstream_vc_o=0, out_port_o=LOCAL.
- Reset mid-packet discards all buffered flits, with no error flagged.

Write side (per VC, independent "in_packet" tracker):
- Accept HEAD/HEADTAIL only when not in_packet. Accept BODY/TAIL only when in_packet.
- HEAD sets in_packet. TAIL clears it. HEADTAIL leaves it clear.
- Violations are dropped (not stored) and set err_o[v]: BODY/TAIL without HEAD, and a repeated HEAD inside a packet.
- Write when full: dropped, err_o[v] set.
- On an accepted HEAD/HEADTAIL, route is computed and stored to the VC's route register:
  - x_dest>X_CURRENT -> EAST; x_dest<X_CURRENT -> WEST;
  - else y_dest>Y_CURRENT -> SOUTH; y_dest<Y_CURRENT -> NORTH;
  - else LOCAL.
- The stored route is visible on out_port_o[v] from the next cycle.

VC FSM:
- IDLE -> VA when the FIFO front is HEAD/HEADTAIL. A head written into an empty VC reaches VA the cycle after the write.
- VA: va_request_o[v]=1. On va_valid_i[v], latch va_new_vc_i[v] into sa_downstream_vc_o[v] and go to ACTIVE.
- ACTIVE: sa_request_o[v] = !is_empty_o[v].
- Grant: sa_valid_i & sa_sel_vc_i==v & !empty.
  - Pops the front flit.
  - Next cycle: xb_valid_o=1 and xb_flit_o = popped flit with vc_id replaced by sa_downstream_vc_o[v]. Latency 1.
- A popped TAIL/HEADTAIL returns the VC to IDLE; the next head is re-requested from IDLE.
- va_valid_i outside VA and sa grants to non-ACTIVE or empty VCs are ignored; no pop, xb_valid_o=0.

Occupancy:
- Simultaneous write and pop on the same VC, including when full, leave occupancy unchanged.
- Pointers wrap modulo BUFFER_SIZE.

On/off:
- Goes 0 when next occupancy >= OFF_THRESHOLD.
- Returns to 1 when next occupancy <= ON_THRESHOLD.
- Otherwise holds.

Optional Feature:
INPUT_PORT_CREDIT_EN:
- Defined: adds output port credit_o [VC_NUM], pulsing 1 for one cycle on the cycle after each pop of VC v, concurrent with xb_valid_o.
- Undefined: no credit_o port, no credit logic.

Test Plan:
1. Reset, then HEADTAIL on VC1 with x_dest=X_CURRENT+1 -> out_port_o[1]=EAST, va_request_o[1]=1 next cycle. va_valid_i[1] with new vc 0 -> sa_request_o[1]=1. Grant -> xb_valid_o=1 after 1 cycle, xb_flit_o.vc_id=0, VC1 IDLE.
2. 4-flit packet on VC0 with no SA grants -> after writes is_empty_o[0]=0 and is_on_off_o[0]=1 (occupancy 4 < 6). 16-flit packet with BUFFER_SIZE=8, no pops -> is_on_off_o[0]=0 at occupancy 6. 9th flit -> dropped, err_o[0]=1, is_full_o[0]=1. Then grant every cycle -> is_on_off_o[0]=1 once occupancy reaches 4.
3. BODY then TAIL on VC0 after reset -> is_empty_o[0] stays 1, err_o[0]=1.
4. HEAD, HEAD, BODY, TAIL on VC1 -> only 3 flits stored, err_o[1]=1. Output order HEAD, BODY, TAIL.
5. Two packets interleaved on VC0/VC1, VA on VC0 at cycle 2 and VC1 at cycle 3, alternating grants -> every flit leaves in per-VC order with the correct downstream vc_id.
6. With INPUT_PORT_CREDIT_EN: 4 pops on VC1 -> exactly 4 credit_o[1] pulses, each aligned with xb_valid_o. Assert rst mid-packet -> all outputs at reset values next cycle.
